// File: rtl/simd_pkg.sv
// Shared types and widths for the SIMD result drain path.
package simd_pkg;
  localparam int LANE_W = 32;
  localparam int LANES  = 4;
  localparam int ADDR_W = 6;
  localparam int BEAT_W = LANE_W * LANES;

  typedef enum logic {BEAT_RES = 1'b0, BEAT_EXT = 1'b1} drain_state_e;

  // One captured bundle: result beat in the upper half, extra beat in the lower.
  typedef struct packed {
    logic [BEAT_W-1:0] res;
    logic [BEAT_W-1:0] ext;
  } bundle_t;
endpackage

// File: rtl/simd_result_fifo.sv
// Bundle FIFO: DEPTH entries of 256 bits, head visible combinationally on rdata.
module simd_result_fifo
  import simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  bundle_t     wdata,
  input  logic        pop,
  output bundle_t     rdata,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count
);
  localparam int PW = $clog2(DEPTH);

  bundle_t         mem [DEPTH];
  logic [PW-1:0]   wp, rp;

  assign rdata = mem[rp];
  assign full  = (count == 4'(DEPTH));
  assign empty = (count == 4'd0);

  // Push into a full FIFO is only issued alongside a pop, so the slot being
  // overwritten is the one the read pointer is leaving.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + 4'(push) - 4'(pop);
    end
  end
endmodule

// File: rtl/simd_result_drain.sv
// Captures four-lane ALU result/extra bundles and drains each as two 128-bit beats.
module simd_result_drain
  import simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              procc_done,
  input  logic [LANE_W-1:0] in_result0,
  input  logic [LANE_W-1:0] in_result1,
  input  logic [LANE_W-1:0] in_result2,
  input  logic [LANE_W-1:0] in_result3,
  input  logic [LANE_W-1:0] in_extra0,
  input  logic [LANE_W-1:0] in_extra1,
  input  logic [LANE_W-1:0] in_extra2,
  input  logic [LANE_W-1:0] in_extra3,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_addr,
  output logic [3:0]        fifo_count,
  output logic              overflow
);
  logic [LANES-1:0][LANE_W-1:0] res_lanes, ext_lanes;
  bundle_t      wr_bundle, head;
  drain_state_e state_q, state_d;
  logic         done_q, capture, accept, push, pop, full, empty;

  // Lane 0 lands in the most significant slot of each beat.
  assign res_lanes = {in_result0, in_result1, in_result2, in_result3};
  assign ext_lanes = {in_extra0, in_extra1, in_extra2, in_extra3};
  assign wr_bundle = '{res: res_lanes, ext: ext_lanes};

  assign capture   = procc_done && !done_q;
  assign out_valid = !empty;
  assign accept    = out_valid && out_ready && !clear;
  assign pop       = accept && (state_q == BEAT_EXT);
  assign push      = capture && !clear && (!full || pop);

  simd_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (wr_bundle),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = (state_q == BEAT_RES) ? head.res : head.ext;
  end
  assign out_last = out_valid && (state_q == BEAT_EXT);

  always_comb begin
    state_d = state_q;
    if (clear)       state_d = BEAT_RES;
    else if (accept) state_d = (state_q == BEAT_RES) ? BEAT_EXT : BEAT_RES;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BEAT_RES;
      done_q   <= 1'b0;
      out_addr <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= procc_done;
      if (clear) begin
        out_addr <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept)                   out_addr <= out_addr + 1'b1;
        if (capture && full && !pop)  overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_simd_result_drain.sv
// Scoreboard bench for simd_result_drain (DEPTH=4).
module tb_simd_result_drain;
  logic         clk = 1'b0, reset = 1'b0, procc_done = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [31:0]  in_result0 = '0, in_result1 = '0, in_result2 = '0, in_result3 = '0;
  logic [31:0]  in_extra0 = '0, in_extra1 = '0, in_extra2 = '0, in_extra3 = '0;
  logic         out_valid, out_last, overflow;
  logic [127:0] out_data;
  logic [5:0]   out_addr;
  logic [3:0]   fifo_count;

  int           total = 0, bad = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_d;
  logic [5:0]   exp_addr = '0;
  logic         exp_last = 1'b0;

  simd_result_drain #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .procc_done(procc_done),
    .in_result0(in_result0), .in_result1(in_result1), .in_result2(in_result2), .in_result3(in_result3),
    .in_extra0(in_extra0), .in_extra1(in_extra1), .in_extra2(in_extra2), .in_extra3(in_extra3),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_addr(out_addr), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Beat checker: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (!out_valid) begin
        total++;
        if (out_data !== 128'd0) begin
          bad++; $display("FAIL idle_data got=%h exp=0", out_data);
        end
      end else if (out_ready && !clear) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_beat got=%h addr=%0d", out_data, out_addr);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_data !== exp_d || out_addr !== exp_addr || out_last !== exp_last) begin
            bad++;
            $display("FAIL beat got data=%h addr=%0d last=%b exp data=%h addr=%0d last=%b",
                     out_data, out_addr, out_last, exp_d, exp_addr, exp_last);
          end
        end
        exp_addr++;
        exp_last = ~exp_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flush();
    exp_q.delete();
    exp_addr = '0;
    exp_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0; flush();
  endtask

  function automatic logic [127:0] mk(input int tag, input int base);
    return {32'(tag * 256 + base), 32'(tag * 256 + base + 1), 32'(tag * 256 + base + 2), 32'(tag * 256 + base + 3)};
  endfunction

  task automatic set_lanes(input logic [127:0] rb, input logic [127:0] eb);
    {in_result0, in_result1, in_result2, in_result3} = rb;
    {in_extra0, in_extra1, in_extra2, in_extra3} = eb;
  endtask

  task automatic capture(input logic [127:0] rb, input logic [127:0] eb, input bit store);
    set_lanes(rb, eb);
    if (store) begin exp_q.push_back(rb); exp_q.push_back(eb); end
    procc_done = 1'b1; tick();
    procc_done = 1'b0; tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && fifo_count != 0; i++) tick();
    total++;
    if (fifo_count !== 4'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL drain count=%0d pending=%0d exp count=0 pending=0", fifo_count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 128'd0 || out_last !== 1'b0 || out_addr !== 6'd0 ||
        fifo_count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_state valid=%b data=%h last=%b addr=%0d count=%0d ovf=%b exp all 0",
                      out_valid, out_data, out_last, out_addr, fifo_count, overflow);
    end
    reset = 1'b1; tick();
  endtask

  task automatic test_single();
    do_clear();
    out_ready = 1'b1;
    set_lanes(128'h00000001_00000002_00000003_00000004, 128'h0000000A_0000000B_0000000C_0000000D);
    exp_q.push_back(128'h00000001_00000002_00000003_00000004);
    exp_q.push_back(128'h0000000A_0000000B_0000000C_0000000D);
    procc_done = 1'b1; tick();
    total++;
    if (out_valid !== 1'b1 || fifo_count !== 4'd1) begin
      bad++; $display("FAIL single_latency valid=%b count=%0d exp valid=1 count=1", out_valid, fifo_count);
    end
    procc_done = 1'b0; tick();
    total++;
    if (out_last !== 1'b1 || out_addr !== 6'd1) begin
      bad++; $display("FAIL single_beat1 last=%b addr=%0d exp last=1 addr=1", out_last, out_addr);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_addr !== 6'd2) begin
      bad++; $display("FAIL single_done valid=%b addr=%0d exp valid=0 addr=2", out_valid, out_addr);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0;
    capture(mk(1, 16), mk(1, 32), 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== mk(1, 16) || out_addr !== 6'd0 ||
          out_last !== 1'b0 || fifo_count !== 4'd1) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d valid=%b data=%h addr=%0d last=%b count=%0d exp data=%h addr=0 count=1",
                        i, out_valid, out_data, out_addr, out_last, fifo_count, mk(1, 16));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_overflow();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) capture(mk(i + 2, 0), mk(i + 2, 64), i < 4);
    total++;
    if (fifo_count !== 4'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_set count=%0d ovf=%b exp count=4 ovf=1", fifo_count, overflow);
    end
    drain();
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky ovf=%b exp 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) capture(mk(i + 10, 0), mk(i + 10, 64), 1'b1);
    out_ready = 1'b1; tick();
    set_lanes(mk(20, 0), mk(20, 64));
    exp_q.push_back(mk(20, 0)); exp_q.push_back(mk(20, 64));
    procc_done = 1'b1; tick();
    out_ready = 1'b0; procc_done = 1'b0;
    total++;
    if (fifo_count !== 4'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_pop count=%0d ovf=%b exp count=4 ovf=0", fifo_count, overflow);
    end
    tick();
    drain();
  endtask

  task automatic test_addr_wrap();
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 33; i++) capture(mk(i + 32, 0), mk(i + 32, 128), 1'b1);
    drain();
    total++;
    if (out_addr !== 6'd2 || overflow !== 1'b0) begin
      bad++; $display("FAIL addr_wrap addr=%0d ovf=%b exp addr=2 ovf=0", out_addr, overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_clear();
    out_ready = 1'b1;
    capture(mk(70, 0), mk(70, 64), 1'b1);
    total++;
    if (out_last !== 1'b1) begin
      bad++; $display("FAIL mid_bundle last=%b exp 1", out_last);
    end
    reset = 1'b0; #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 128'd0 || out_last !== 1'b0 || out_addr !== 6'd0 ||
        fifo_count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset valid=%b data=%h last=%b addr=%0d count=%0d ovf=%b exp all 0",
                      out_valid, out_data, out_last, out_addr, fifo_count, overflow);
    end
    flush();
    tick(); reset = 1'b1; tick();
    capture(mk(71, 0), mk(71, 64), 1'b1);
    drain();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) capture(mk(i + 80, 0), mk(i + 80, 64), 1'b1);
    total++;
    if (fifo_count !== 4'd3) begin
      bad++; $display("FAIL clear_fill count=%0d exp 3", fifo_count);
    end
    clear = 1'b1; tick(); clear = 1'b0; flush();
    total++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0 || out_addr !== 6'd0) begin
      bad++; $display("FAIL clear count=%0d valid=%b addr=%0d exp 0 0 0", fifo_count, out_valid, out_addr);
    end
  endtask

  task automatic test_held_done();
    do_clear();
    out_ready = 1'b0;
    set_lanes(mk(90, 0), mk(90, 64));
    exp_q.push_back(mk(90, 0)); exp_q.push_back(mk(90, 64));
    procc_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    procc_done = 1'b0; tick();
    total++;
    if (fifo_count !== 4'd1) begin
      bad++; $display("FAIL held_done count=%0d exp 1", fifo_count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_addr_wrap();
    test_mid_reset();
    test_clear();
    test_held_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_result_drain.md
SIMD_RESULT_DRAIN -- requirements
Module: simd_result_drain

Interface
REQ-001 Parameter DEPTH, default 4, meaning bundle FIFO depth in entries; legal values are powers of two from 2 to 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 procc_done  input  1  level, AND of the four ALU done flags; a bundle is ready on its rising edge.
REQ-005 in_result0..in_result3  input  32 each  ALU result lanes 0..3.
REQ-006 in_extra0..in_extra3  input  32 each  ALU extra_result lanes 0..3.
REQ-007 clear  input  1  synchronous flush; clears FIFO, address and overflow.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_data  output  128  beat payload.
REQ-011 out_last  output  1  high on the second (extra) beat of a bundle.
REQ-012 out_addr  output  6  writeback address of the current beat.
REQ-013 fifo_count  output  4  number of bundles stored, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag: a bundle was dropped.

Function
REQ-015 Register procc_done into done_q; a capture event is procc_done=1 and done_q=0, sampled at a rising clk edge.
REQ-016 On a capture event with the FIFO not full, all eight lanes SHALL be written into one FIFO entry at that edge.
REQ-017 Beat 0 of a bundle SHALL be {in_result0, in_result1, in_result2, in_result3}, with lane 0 at bits [127:96].
REQ-018 Beat 1 SHALL be {in_extra0..in_extra3}, using the same lane order.
REQ-019 out_valid SHALL be high exactly when fifo_count>0, starting the cycle after the capturing edge; capture-to-valid latency is 1 cycle.
REQ-020 The FSM SHALL have states BEAT_RES and BEAT_EXT; it resets to BEAT_RES.
REQ-021 A beat is accepted when out_valid=1 and out_ready=1 at the clock edge.
REQ-022 On acceptance in BEAT_RES, the FSM moves to BEAT_EXT.
REQ-023 On acceptance in BEAT_EXT, the FIFO head is popped and the FSM returns to BEAT_RES.
REQ-024 out_last SHALL equal (state==BEAT_EXT) and out_valid.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and out_addr SHALL be held stable.
REQ-026 out_data SHALL be 0 whenever out_valid=0.
REQ-027 out_addr SHALL increment by 1 per accepted beat and wrap from 63 to 0.
REQ-028 Back-to-back bundles SHALL stream with no bubble: after a BEAT_EXT acceptance with fifo_count>1, the next beat-0 is valid in the following cycle.
REQ-029 A capture when full SHALL drop the bundle, set overflow, and leave the FIFO unchanged.
REQ-030 Exception to REQ-029: if a BEAT_EXT acceptance occurs in the same cycle as a capture when full, the pop frees the slot, the capture is stored, fifo_count stays DEPTH, and overflow is not set.
REQ-031 A simultaneous capture and pop with the FIFO not full SHALL leave fifo_count unchanged.
REQ-032 clear SHALL have priority over capture and acceptance.
REQ-033 clear SHALL set fifo_count=0, out_addr=0, overflow=0 and the FSM to BEAT_RES; done_q still updates.
REQ-034 A held-high procc_done SHALL produce only one capture.

Reset
REQ-035 While reset=0, all state SHALL be cleared asynchronously: out_valid=0, out_data=0, out_last=0, out_addr=0, fifo_count=0, overflow=0, done_q=0, FSM=BEAT_RES.
REQ-036 Reset asserted mid-bundle SHALL discard any partially sent bundle; after release, the first beat of the next capture is beat 0 at out_addr 0.

Structure
REQ-037 Shared package simd_pkg SHALL hold LANE_W=32, LANES=4, ADDR_W=6 and the drain state enum.
REQ-038 The FIFO storage SHALL be one sub-module, simd_result_fifo: 256-bit wide, DEPTH deep, with push, pop, full, empty and count.

Verification
REQ-039 Single bundle: results 1,2,3,4 and extras A,B,C,D with out_ready=1 -> beat0=0x00000001_00000002_00000003_00000004 at addr 0, beat1=0x0000000A_0000000B_0000000C_0000000D at addr 1 with out_last=1.
REQ-040 Backpressure: out_ready=0 for 5 cycles after valid -> beat0 held stable for 5 cycles, out_addr still 0, fifo_count=1.
REQ-041 Overflow: 5 captures with out_ready=0 and DEPTH=4 -> fifo_count=4, overflow=1, and the drained beats match captures 1-4 only.
REQ-042 Full plus simultaneous pop: FIFO full, capture coinciding with a BEAT_EXT acceptance -> overflow=0, fifo_count=4, and the new bundle is drained last.
REQ-043 Address wrap: 33 bundles drained -> beat 64 appears at out_addr 0.
REQ-044 Mid-operation events: reset=0 between beat0 and beat1 -> all outputs 0 immediately; clear with 3 stored bundles -> fifo_count=0 and out_valid=0 next cycle.
